// File: rtl/loader_pkg.sv
// Shared boot-loader definitions: loader FSM states and the
// host-frame and ROM-map constants used by the CPU glue.
package loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
      S_CHK,
      S_RUN,
      S_ERR
   } state_e;

   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

   // CPU fetch address that maps onto ROM index 0
   localparam logic [7:0] ROM_BASE = 8'h80;

endpackage

// File: rtl/prog_loader.sv
// Boot loader: parses SYNC/LEN/payload/CHK frames from the host link,
// writes the payload into program ROM and releases the CPU on a good sum.
module prog_loader
   import loader_pkg::*;
#(
   parameter int          ADDR_W    = 7,
   parameter logic [7:0]  SYNC_BYTE = SYNC_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              rom_we,
   output logic [ADDR_W-1:0] rom_addr,
   output logic [7:0]        rom_wdata,
   output logic              cpu_reset,
   output logic              done,
   output logic              err
);

   localparam int CNT_W = ADDR_W + 1;
   localparam logic [8:0] DEPTH = 9'(1 << ADDR_W);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    len_q, len_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [7:0]          sum_q, sum_d;
   logic                rom_we_q, rom_we_d;
   logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
   logic [7:0]          rom_wdata_q, rom_wdata_d;
   logic                cpu_reset_q, cpu_reset_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   logic                acc;
   logic                is_sync;
   logic                len_bad;
   logic [7:0]          chk_sum;

   assign in_ready = 1'b1;
   assign acc      = in_valid;
   assign is_sync  = (in_data == SYNC_BYTE);
   assign len_bad  = (in_data == 8'h00) || ({1'b0, in_data} > DEPTH);
   assign chk_sum  = sum_q + in_data;

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      count_d     = count_q;
      sum_d       = sum_q;
      rom_we_d    = 1'b0;
      rom_addr_d  = rom_addr_q;
      rom_wdata_d = rom_wdata_q;
      cpu_reset_d = cpu_reset_q;
      done_d      = done_q;
      err_d       = err_q;

      unique case (state_q)
         S_IDLE: begin
            if (acc && is_sync) begin
               state_d = S_LEN;
            end
         end
         S_LEN: begin
            if (acc) begin
               if (len_bad) begin
                  state_d     = S_ERR;
                  err_d       = 1'b1;
                  done_d      = 1'b0;
                  cpu_reset_d = 1'b1;
               end else begin
                  len_d   = CNT_W'(in_data);
                  count_d = '0;
                  sum_d   = '0;
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (acc) begin
               rom_we_d    = 1'b1;
               rom_addr_d  = count_q[ADDR_W-1:0];
               rom_wdata_d = in_data;
               count_d     = count_q + CNT_W'(1);
               sum_d       = sum_q + in_data;
               if (count_q == len_q - CNT_W'(1)) begin
                  state_d = S_CHK;
               end
            end
         end
         S_CHK: begin
            if (acc) begin
               if (chk_sum == 8'h00) begin
                  state_d     = S_RUN;
                  done_d      = 1'b1;
                  err_d       = 1'b0;
                  cpu_reset_d = 1'b0;
               end else begin
                  state_d     = S_ERR;
                  err_d       = 1'b1;
                  done_d      = 1'b0;
                  cpu_reset_d = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (acc && is_sync) begin
               state_d     = S_LEN;
               cpu_reset_d = 1'b1;
               done_d      = 1'b0;
               err_d       = 1'b0;
            end
         end
         S_ERR: begin
            if (acc && is_sync) begin
               state_d = S_LEN;
               err_d   = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         count_q     <= '0;
         sum_q       <= '0;
         rom_we_q    <= 1'b0;
         rom_addr_q  <= '0;
         rom_wdata_q <= '0;
         cpu_reset_q <= 1'b1;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         count_q     <= count_d;
         sum_q       <= sum_d;
         rom_we_q    <= rom_we_d;
         rom_addr_q  <= rom_addr_d;
         rom_wdata_q <= rom_wdata_d;
         cpu_reset_q <= cpu_reset_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign rom_we    = rom_we_q;
   assign rom_addr  = rom_addr_q;
   assign rom_wdata = rom_wdata_q;
   assign cpu_reset = cpu_reset_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames with hand-computed sums,
// ROM writes captured into a shadow memory and checked afterwards.
module tb_prog_loader;

   logic       clk;
   logic       reset;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       rom_we;
   logic [6:0] rom_addr;
   logic [7:0] rom_wdata;
   logic       cpu_reset;
   logic       done;
   logic       err;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] mem [128];
   int         wr_cnt = 0;
   logic [6:0] last_addr = '0;

   prog_loader dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .rom_we    (rom_we),
      .rom_addr  (rom_addr),
      .rom_wdata (rom_wdata),
      .cpu_reset (cpu_reset),
      .done      (done),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rom_we) begin
         mem[rom_addr] = rom_wdata;
         last_addr     = rom_addr;
         wr_cnt        = wr_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      in_data  = b;
      in_valid = 1'b1;
      @(negedge clk);
   endtask

   task automatic gap(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_status(input string tag, input logic d,
                             input logic e, input logic c);
      check({tag, ".done"}, 32'(done), 32'(d));
      check({tag, ".err"}, 32'(err), 32'(e));
      check({tag, ".cpu_reset"}, 32'(cpu_reset), 32'(c));
   endtask

   int base;
   int bad_bytes;

   initial begin
      reset    = 1'b0;
      in_data  = 8'h00;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst.rom_we", 32'(rom_we), 32'(0));
      check("rst.rom_addr", 32'(rom_addr), 32'(0));
      check("rst.rom_wdata", 32'(rom_wdata), 32'(0));
      chk_status("rst", 1'b0, 1'b0, 1'b1);
      check("rst.in_ready", 32'(in_ready), 32'(1));
      reset = 1'b1;
      @(negedge clk);

      // good frame
      base = wr_cnt;
      send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
      check("good.hold_before_chk", 32'(cpu_reset), 32'(1));
      send(8'h9A);
      gap(2);
      check("good.writes", 32'(wr_cnt - base), 32'(3));
      check("good.mem0", 32'(mem[0]), 32'h11);
      check("good.mem1", 32'(mem[1]), 32'h22);
      check("good.mem2", 32'(mem[2]), 32'h33);
      check("good.we_idle", 32'(rom_we), 32'(0));
      chk_status("good", 1'b1, 1'b0, 1'b0);

      // reload from RUN, then bad checksum
      base = wr_cnt;
      send(8'hA5);
      chk_status("reload", 1'b0, 1'b0, 1'b1);
      send(8'h02); send(8'h01); send(8'h02); send(8'h00);
      gap(1);
      check("badchk.writes", 32'(wr_cnt - base), 32'(2));
      chk_status("badchk", 1'b0, 1'b1, 1'b1);
      send(8'hA5);
      check("errclr.err", 32'(err), 32'(0));
      send(8'h01); send(8'h05); send(8'hFB);
      gap(1);
      check("recover.mem0", 32'(mem[0]), 32'h05);
      chk_status("recover", 1'b1, 1'b0, 1'b0);

      // length errors
      base = wr_cnt;
      send(8'hA5); send(8'h00);
      gap(2);
      chk_status("len0", 1'b0, 1'b1, 1'b1);
      send(8'hA5); send(8'h81);
      gap(2);
      chk_status("len129", 1'b0, 1'b1, 1'b1);
      check("lenerr.writes", 32'(wr_cnt - base), 32'(0));

      // maximum length: 128 x 01, sum 80, CHK 80
      base = wr_cnt;
      send(8'hA5); send(8'h80);
      for (int i = 0; i < 128; i++) send(8'h01);
      send(8'h80);
      gap(1);
      check("max.writes", 32'(wr_cnt - base), 32'(128));
      check("max.last_addr", 32'(last_addr), 32'h7F);
      bad_bytes = 0;
      for (int i = 0; i < 128; i++) if (mem[i] !== 8'h01) bad_bytes++;
      check("max.contents", 32'(bad_bytes), 32'(0));
      chk_status("max", 1'b1, 1'b0, 1'b0);

      // junk in ERR, A5 as payload, random stalls
      send(8'hA5); send(8'h00);
      gap(1);
      base = wr_cnt;
      send(8'h00); send(8'hFF);
      check("junk.err_held", 32'(err), 32'(1));
      send(8'hA5); gap($urandom_range(0, 3));
      send(8'h04); gap($urandom_range(0, 3));
      send(8'hA5); gap(2);
      check("stall.we_gap", 32'(rom_we), 32'(0));
      send(8'h10); gap($urandom_range(0, 3));
      send(8'h20); gap($urandom_range(0, 3));
      send(8'h30); gap($urandom_range(0, 3));
      send(8'hFB);
      gap(1);
      check("stall.writes", 32'(wr_cnt - base), 32'(4));
      check("stall.mem0", 32'(mem[0]), 32'hA5);
      check("stall.mem1", 32'(mem[1]), 32'h10);
      check("stall.mem3", 32'(mem[3]), 32'h30);
      chk_status("stall", 1'b1, 1'b0, 1'b0);

      // reset mid-frame
      send(8'hA5); send(8'h04); send(8'h01); send(8'h02);
      check("mid.we_before", 32'(rom_we), 32'(1));
      #2 reset = 1'b0;
      #1;
      check("mid.we", 32'(rom_we), 32'(0));
      chk_status("mid", 1'b0, 1'b0, 1'b1);
      in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      send(8'hA5); send(8'h01); send(8'h05); send(8'hFB);
      gap(1);
      check("post.mem0", 32'(mem[0]), 32'h05);
      chk_status("post", 1'b1, 1'b0, 1'b0);
      send(8'hA5);
      check("rerun.cpu_reset", 32'(cpu_reset), 32'(1));
      gap(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream boot stage for the 8-bit CPU. Receives a framed byte stream from a host link (valid/ready) and writes the payload into the program ROM write port.
- Holds the CPU in reset while loading. Releases it only after a frame passes its checksum.
- Sits between the host byte source and the CPU/ROM pair. The CPU then fetches from 0x80, i.e. ROM index 0.

Parameters:
- ADDR_W, 7, ROM index width; depth = 2**ADDR_W
- SYNC_BYTE, 8'hA5, frame start marker

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- in_data  in  8  host byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts byte; transfer when in_valid && in_ready
- rom_we  out  1  ROM write strobe (one clk per byte)
- rom_addr  out  ADDR_W  ROM write index
- rom_wdata  out  8  ROM write data
- cpu_reset  out  1  active-high, synchronous-style hold to CPU reset input
- done  out  1  last frame loaded OK, CPU running
- err  out  1  last frame failed (length or checksum)

Behaviour:
- Frame format: SYNC_BYTE, LEN (1..2**ADDR_W), LEN payload bytes, CHK.
  - CHK is valid when (sum of payload + CHK) mod 256 == 0.
- All outputs are registered.
- Reset (reset low, async) sets:
  - state=S_IDLE, cpu_reset=1, rom_we=0, rom_addr=0, rom_wdata=0, done=0, err=0
  - count=0, sum=0
- in_ready = 1 in every state. "Accept" means in_valid && in_ready at a clk edge.
- States:
  - S_IDLE: accept SYNC_BYTE -> S_LEN. Other bytes are discarded.
  - S_LEN: byte==0 or byte>2**ADDR_W -> S_ERR. Otherwise latch len=byte, count=0, sum=0 -> S_DATA.
  - S_DATA: each accept sets rom_we=1, rom_addr=count[ADDR_W-1:0], rom_wdata=byte at the next edge (latency 1). Also count+=1 and sum+=byte (mod 256). When count reaches len-1 on an accept -> S_CHK.
  - S_CHK: on accept, (sum+byte)[7:0]==0 -> S_RUN with done=1, err=0, cpu_reset=0. Else -> S_ERR.
  - S_RUN: cpu_reset=0, done=1. A SYNC_BYTE accept sets cpu_reset=1, done=0, err=0 -> S_LEN (reload). Other bytes are discarded.
  - S_ERR: cpu_reset=1, err=1, done=0. A SYNC_BYTE accept sets err=0 -> S_LEN. Other bytes are discarded.
- Timing rules:
  - rom_we is a 1-cycle pulse per payload byte. It is 0 in all other cycles.
  - cpu_reset deasserts on the same edge that enters S_RUN. The final payload write has already retired at least one edge earlier.
- Boundary conditions:
  - LEN = 2**ADDR_W: addresses 0..2**ADDR_W-1 are written, with no wrap.
  - count is ADDR_W+1 bits wide so len=128 is representable.
  - A SYNC_BYTE value inside S_LEN/S_DATA/S_CHK is treated as data, with no resync.
  - Gaps (in_valid low) in any state: hold state, rom_we=0.
  - Asserting reset mid-frame aborts immediately. Partially written ROM is left as is, and cpu_reset returns to 1.
  - Entering S_LEN from S_RUN/S_ERR clears done/err on that edge.

Decomposition:
- Shared package loader_pkg holds:
  - the state enum (S_IDLE, S_LEN, S_DATA, S_CHK, S_RUN, S_ERR)
  - the SYNC_BYTE default
  - the ROM base constant 8'h80 used by the CPU and top-level decode
- Single module. The checksum accumulator is a few lines, so no sub-module is warranted.

Test Plan:
- Good frame: send A5,03,11,22,33,9A.
  - Expect three rom_we pulses at addr 0/1/2 with data 11/22/33.
  - cpu_reset falls after 9A; done=1, err=0.
- Bad checksum: send A5,02,01,02,00.
  - Expect err=1, done=0, cpu_reset=1, two ROM writes.
  - Then a good frame A5,01,05,FB gives done=1.
- Length error: send A5,00. Expect S_ERR, err=1, zero rom_we pulses.
  - Then A5,81 (129) also gives err=1.
- Max length: LEN=80 hex (128 bytes of 01), CHK=80.
  - Expect writes to addr 0..127, last addr 7F, done=1.
- Stalls and noise: random in_valid gaps during a good frame give identical ROM contents.
  - Junk bytes 00,FF before A5 are ignored.
  - A5 as a payload byte is written as data.
- Reset mid-frame: drive reset low after 2 payload bytes.
  - Outputs return immediately to their reset values (cpu_reset=1, rom_we=0).
  - A subsequent good frame loads normally. In S_RUN, sending A5 re-asserts cpu_reset next edge.
